// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles every bus signal around the shared ALU arbiter.
//   Requester side : req_valid/req_ready/req_cmd handshake plus the
//                    rsp_valid/rsp_data/rsp_addr response and the
//                    grant_id/busy status.
//   ALU side       : registered operands alu_* driven to the ALU and
//                    the combinational results alu_rd/alu_mem_addr.
//   Modports       : slave  - the arbiter itself
//                    master - the surrounding environment (requesters + ALU)
//   req_cmd packing: requester i occupies [i*CMD_W +: CMD_W]; fields MSB
//                    to LSB are {pc, rs1, rs2, imm[11:0], shamt[4:0],
//                    funct7[6:0], funct3[2:0], opcode[6:0]}.
interface alu_share_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  localparam int CMD_W = 3*WIDTH + 34;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*CMD_W-1:0] req_cmd;

  logic [WIDTH-1:0]         alu_pc;
  logic [WIDTH-1:0]         alu_rs1;
  logic [WIDTH-1:0]         alu_rs2;
  logic [11:0]              alu_imm;
  logic [4:0]               alu_shamt;
  logic [6:0]               alu_funct7;
  logic [2:0]               alu_funct3;
  logic [6:0]               alu_opcode;
  logic [WIDTH-1:0]         alu_rd;
  logic [WIDTH-1:0]         alu_mem_addr;

  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic [WIDTH-1:0]         rsp_addr;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  modport slave (
    input  req_valid, req_cmd, alu_rd, alu_mem_addr,
    output req_ready, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_shamt,
           alu_funct7, alu_funct3, alu_opcode,
           rsp_valid, rsp_data, rsp_addr, grant_id, busy
  );

  modport master (
    output req_valid, req_cmd, alu_rd, alu_mem_addr,
    input  req_ready, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_shamt,
           alu_funct7, alu_funct3, alu_opcode,
           rsp_valid, rsp_data, rsp_addr, grant_id, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between NUM_REQ requesters. A winner is
//   picked in IDLE, its command is latched into the alu_* registers, the
//   ALU result is captured one cycle later and returned as a one-cycle
//   one-hot rsp_valid pulse. Each operation occupies exactly three cycles
//   (IDLE -> EXEC -> RESP); there is no pipelining.
// Ports
//   clk - system clock
//   rst - synchronous active-high reset (aborts any in-flight operation)
//   bus - alu_share_arbiter_if.slave: requester handshake, ALU operand /
//         result bus, response and status outputs
// Build option
//   ALU_ARB_FIXED_PRIO_EN - when defined, lowest requester index always
//   wins and the round-robin pointer is dropped. Undefined (default):
//   round-robin starting after the last winner.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic             clk,
  input logic             rst,
  alu_share_arbiter_if.slave bus
);
  localparam int CMD_W   = 3*WIDTH + 34;
  localparam int OP_LSB  = 0;
  localparam int F3_LSB  = 7;
  localparam int F7_LSB  = 10;
  localparam int SH_LSB  = 17;
  localparam int IMM_LSB = 22;
  localparam int RS2_LSB = 34;
  localparam int RS1_LSB = 34 + WIDTH;
  localparam int PC_LSB  = 34 + 2*WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]    r_rr_ptr;
`endif
  logic [WIDTH-1:0]   r_alu_pc;
  logic [WIDTH-1:0]   r_alu_rs1;
  logic [WIDTH-1:0]   r_alu_rs2;
  logic [11:0]        r_alu_imm;
  logic [4:0]         r_alu_shamt;
  logic [6:0]         r_alu_funct7;
  logic [2:0]         r_alu_funct3;
  logic [6:0]         r_alu_opcode;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [WIDTH-1:0]   r_rsp_addr;

  logic [CMD_W-1:0]   w_cmd [NUM_REQ];
  logic [CMD_W-1:0]   w_sel_cmd;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_grant_onehot;
  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_cmd[gi]          = bus.req_cmd[gi*CMD_W +: CMD_W];
      // Ready is suppressed while rst is high so no requester sees a
      // handshake that the reset edge would throw away.
      assign w_ready[gi]        = (r_state == ST_IDLE) && !rst && w_found &&
                                  (w_winner == ID_W'(gi));
      assign w_grant_onehot[gi] = (r_grant_id == ID_W'(gi));
    end
  endgenerate

  // Winner search. The loop runs from lowest to highest priority so the
  // last hit (highest priority) is the one that sticks.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'(k);
      if (bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`else
    // Priority order is rr_ptr+1, rr_ptr+2, ... with wrap-around; works
    // for NUM_REQ that is not a power of two.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (int'(r_rr_ptr) + k >= NUM_REQ) begin
        w_idx = ID_W'(int'(r_rr_ptr) + k - NUM_REQ);
      end else begin
        w_idx = ID_W'(int'(r_rr_ptr) + k);
      end
      if (bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`endif
  end

  assign w_sel_cmd = w_cmd[w_winner];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_rr_ptr     <= ID_W'(NUM_REQ - 1);
`endif
      r_alu_pc     <= '0;
      r_alu_rs1    <= '0;
      r_alu_rs2    <= '0;
      r_alu_imm    <= '0;
      r_alu_shamt  <= '0;
      r_alu_funct7 <= '0;
      r_alu_funct3 <= '0;
      r_alu_opcode <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_addr   <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_alu_pc     <= w_sel_cmd[PC_LSB  +: WIDTH];
            r_alu_rs1    <= w_sel_cmd[RS1_LSB +: WIDTH];
            r_alu_rs2    <= w_sel_cmd[RS2_LSB +: WIDTH];
            r_alu_imm    <= w_sel_cmd[IMM_LSB +: 12];
            r_alu_shamt  <= w_sel_cmd[SH_LSB  +: 5];
            r_alu_funct7 <= w_sel_cmd[F7_LSB  +: 7];
            r_alu_funct3 <= w_sel_cmd[F3_LSB  +: 3];
            r_alu_opcode <= w_sel_cmd[OP_LSB  +: 7];
            r_grant_id   <= w_winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_rr_ptr     <= w_winner;
`endif
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data   <= bus.alu_rd;
          r_rsp_addr   <= bus.alu_mem_addr;
          r_rsp_valid  <= w_grant_onehot;
          // Park the ALU on opcode 0 (RD=0) while the result is returned.
          r_alu_opcode <= '0;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.alu_pc     = r_alu_pc;
  assign bus.alu_rs1    = r_alu_rs1;
  assign bus.alu_rs2    = r_alu_rs2;
  assign bus.alu_imm    = r_alu_imm;
  assign bus.alu_shamt  = r_alu_shamt;
  assign bus.alu_funct7 = r_alu_funct7;
  assign bus.alu_funct3 = r_alu_funct3;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_addr   = r_rsp_addr;
  assign bus.grant_id   = r_grant_id;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter. A small behavioural ALU sits
//   on the ALU side of the interface; a scoreboard queue gets an entry at
//   every handshake and is popped on every rsp_valid pulse. Scenario tasks
//   add their own cycle-exact checks.
module tb_alu_share_arbiter;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CMD_W   = 3*WIDTH + 34;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [NUM_REQ-1:0]       tb_valid;
  logic [NUM_REQ*CMD_W-1:0] tb_cmd_bus;
  assign bus.req_valid = tb_valid;
  assign bus.req_cmd   = tb_cmd_bus;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_rd(input logic [31:0] pc, input logic [31:0] rs1,
                                         input logic [31:0] rs2, input logic [11:0] imm,
                                         input logic [4:0] sh, input logic [6:0] f7,
                                         input logic [2:0] f3, input logic [6:0] op);
    logic [31:0] simm;
    simm = {{20{imm[11]}}, imm};
    case (op)
      OP_R:    ref_rd = (f3 == 3'd0) ? ((f7 == 7'h20) ? rs1 - rs2 : rs1 + rs2) :
                        (f3 == 3'd7) ? (rs1 & rs2) : (rs1 ^ rs2);
      OP_I:    ref_rd = (f3 == 3'd1) ? (rs1 << sh) : (rs1 + simm);
      OP_JAL:  ref_rd = pc + 32'd4;
      default: ref_rd = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] rs1, input logic [11:0] imm,
                                           input logic [6:0] op);
    ref_addr = (op == OP_LOAD || op == OP_STORE) ? rs1 + {{20{imm[11]}}, imm} : 32'd0;
  endfunction

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [31:0] pc, input logic [31:0] rs1,
                                              input logic [31:0] rs2, input logic [11:0] imm,
                                              input logic [4:0] sh, input logic [6:0] f7,
                                              input logic [2:0] f3, input logic [6:0] op);
    mk_cmd = {pc, rs1, rs2, imm, sh, f7, f3, op};
  endfunction

  // Behavioural ALU driven by the arbiter's registered operands.
  always_comb begin
    bus.alu_rd       = ref_rd(bus.alu_pc, bus.alu_rs1, bus.alu_rs2, bus.alu_imm,
                              bus.alu_shamt, bus.alu_funct7, bus.alu_funct3, bus.alu_opcode);
    bus.alu_mem_addr = ref_addr(bus.alu_rs1, bus.alu_imm, bus.alu_opcode);
  end

  typedef struct {
    int          id;
    logic [31:0] rd;
    logic [31:0] addr;
    int          hs;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: push at handshake (mid-cycle before the accepting edge),
  // pop on each response pulse, which must land two cycles later.
  always @(negedge clk) begin
    exp_t e;
    logic [CMD_W-1:0] c;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.req_ready != '0) begin
        n_total++;
        if ($countones(bus.req_ready) != 1 || (bus.req_ready & ~tb_valid) != '0)
          $display("FAIL ready_onehot: got %b want one-hot subset of %b", bus.req_ready, tb_valid);
        else n_pass++;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tb_valid[i] && bus.req_ready[i]) begin
          c      = tb_cmd_bus[i*CMD_W +: CMD_W];
          e.id   = i;
          e.rd   = ref_rd(c[129:98], c[97:66], c[65:34], c[33:22], c[21:17], c[16:10], c[9:7], c[6:0]);
          e.addr = ref_addr(c[97:66], c[33:22], c[6:0]);
          e.hs   = cyc;
          sb.push_back(e);
          $display("grant req%0d cyc=%0d", i, cyc);
        end
      end
      if (bus.rsp_valid != '0) begin
        $display("rsp valid=%b data=%h addr=%h cyc=%0d", bus.rsp_valid, bus.rsp_data, bus.rsp_addr, cyc);
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got rsp_valid %b want no response", bus.rsp_valid);
        end else begin
          n_pass++;
          e = sb.pop_front();
          n_total++;
          if (bus.rsp_valid !== (4'b0001 << e.id)) $display("FAIL sb_valid: got %b want %b", bus.rsp_valid, 4'b0001 << e.id);
          else n_pass++;
          n_total++;
          if (bus.rsp_data !== e.rd) $display("FAIL sb_data: got %h want %h", bus.rsp_data, e.rd);
          else n_pass++;
          n_total++;
          if (bus.rsp_addr !== e.addr) $display("FAIL sb_addr: got %h want %h", bus.rsp_addr, e.addr);
          else n_pass++;
          n_total++;
          if (cyc != e.hs + 2) $display("FAIL sb_latency: got %0d want %0d", cyc - e.hs, 2);
          else n_pass++;
          n_total++;
          if (bus.grant_id !== ID_W'(e.id)) $display("FAIL sb_grant: got %0d want %0d", bus.grant_id, e.id);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [CMD_W-1:0] c);
    tb_cmd_bus[i*CMD_W +: CMD_W] = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0) $display("FAIL rst_ready: got %b want 0000", bus.req_ready); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0) $display("FAIL rst_rsp_valid: got %b want 0000", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 32'd0) $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data); else n_pass++;
    n_total++; if (bus.rsp_addr !== 32'd0) $display("FAIL rst_rsp_addr: got %h want 0", bus.rsp_addr); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.grant_id !== 2'd0) $display("FAIL rst_grant: got %0d want 0", bus.grant_id); else n_pass++;
    n_total++; if (bus.alu_opcode !== 7'd0) $display("FAIL rst_opcode: got %h want 0", bus.alu_opcode); else n_pass++;
    n_total++; if (bus.alu_rs1 !== 32'd0 || bus.alu_pc !== 32'd0) $display("FAIL rst_operands: got %h/%h want 0/0", bus.alu_rs1, bus.alu_pc); else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    tick();
    set_cmd(1, mk_cmd(32'd0, 32'd5, 32'd7, 12'd0, 5'd0, 7'd0, 3'd0, OP_R));
    tb_valid[1] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL add_ready: got %b want 0010", bus.req_ready); else n_pass++;
    tick();
    tb_valid[1] = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL add_busy: got %b want 1", bus.busy); else n_pass++;
    n_total++; if (bus.alu_rs1 !== 32'd5 || bus.alu_rs2 !== 32'd7) $display("FAIL add_operands: got %0d/%0d want 5/7", bus.alu_rs1, bus.alu_rs2); else n_pass++;
    n_total++; if (bus.alu_opcode !== OP_R) $display("FAIL add_opcode: got %b want %b", bus.alu_opcode, OP_R); else n_pass++;
    n_total++; if (bus.rsp_valid !== 4'b0) $display("FAIL add_early_rsp: got %b want 0000", bus.rsp_valid); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 4'b0010) $display("FAIL add_rsp_valid: got %b want 0010", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 32'd12) $display("FAIL add_rsp_data: got %0d want 12", bus.rsp_data); else n_pass++;
    n_total++; if (bus.alu_opcode !== 7'd0) $display("FAIL add_resp_opcode: got %b want 0", bus.alu_opcode); else n_pass++;
    n_total++; if (bus.alu_rs1 !== 32'd5) $display("FAIL add_resp_hold: got %0d want 5", bus.alu_rs1); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) $display("FAIL add_idle: got valid %b busy %b want 0000 0", bus.rsp_valid, bus.busy); else n_pass++;
    n_total++; if (bus.rsp_data !== 32'd12) $display("FAIL add_data_hold: got %0d want 12", bus.rsp_data); else n_pass++;
  endtask

  task automatic test_sub_load();
    tick();
    set_cmd(2, mk_cmd(32'd0, 32'd20, 32'd7, 12'd0, 5'd0, 7'h20, 3'd0, OP_R));
    tb_valid[2] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL sub_ready: got %b want 0100", bus.req_ready); else n_pass++;
    tick();
    tb_valid[2] = 1'b0;
    tick();
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'd13) $display("FAIL sub_rsp: got %b/%0d want 0100/13", bus.rsp_valid, bus.rsp_data); else n_pass++;
    tick();
    set_cmd(0, mk_cmd(32'd0, 32'h100, 32'd0, 12'd8, 5'd0, 7'd0, 3'd2, OP_LOAD));
    tb_valid[0] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL load_ready: got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    tb_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_addr !== 32'h108) $display("FAIL load_rsp: got %b/%h want 0001/108", bus.rsp_valid, bus.rsp_addr); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready, exp_rsp, oh;
    tick();
    rst = 1'b1;
    set_cmd(0, mk_cmd(32'd0, 32'h10, 32'd0, 12'd1, 5'd0, 7'd0, 3'd0, OP_I));
    set_cmd(1, mk_cmd(32'd0, 32'h200, 32'd0, 12'hffc, 5'd0, 7'd0, 3'd2, OP_STORE));
    set_cmd(2, mk_cmd(32'd0, 32'd3, 32'd0, 12'd0, 5'd4, 7'd0, 3'd1, OP_I));
    set_cmd(3, mk_cmd(32'h400, 32'd0, 32'd0, 12'd0, 5'd0, 7'd0, 3'd0, OP_JAL));
    tb_valid = 4'b1111;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      oh        = 4'b0001 << ((k / 3) % 4);
      exp_ready = (k % 3 == 0) ? oh : 4'b0;
      exp_rsp   = (k % 3 == 2) ? oh : 4'b0;
      @(negedge clk);
      n_total++; if (bus.req_ready !== exp_ready) $display("FAIL rr_ready c%0d: got %b want %b", k, bus.req_ready, exp_ready); else n_pass++;
      n_total++; if (bus.rsp_valid !== exp_rsp) $display("FAIL rr_rsp c%0d: got %b want %b", k, bus.rsp_valid, exp_rsp); else n_pass++;
      tick();
    end
    tb_valid = 4'b0;
  endtask

  task automatic test_busy_block();
    tick();
    set_cmd(0, mk_cmd(32'd0, 32'd1, 32'd2, 12'd0, 5'd0, 7'd0, 3'd0, OP_R));
    tb_valid[0] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL busy_first_ready: got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    tb_valid[0] = 1'b0;
    set_cmd(3, mk_cmd(32'd0, 32'd1000, 32'd1, 12'd0, 5'd0, 7'h20, 3'd0, OP_R));
    tb_valid[3] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0 || bus.busy !== 1'b1) $display("FAIL busy_exec_block: got %b busy %b want 0000 1", bus.req_ready, bus.busy); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0) $display("FAIL busy_resp_block: got %b want 0000", bus.req_ready); else n_pass++;
    n_total++; if (bus.rsp_data !== 32'd3) $display("FAIL busy_first_data: got %0d want 3", bus.rsp_data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b1000) $display("FAIL busy_late_ready: got %b want 1000", bus.req_ready); else n_pass++;
    tick();
    tb_valid[3] = 1'b0;
    set_cmd(3, mk_cmd(32'd0, 32'd5, 32'd5, 12'd0, 5'd0, 7'd0, 3'd0, OP_R));
    @(negedge clk);
    n_total++; if (bus.alu_rs1 !== 32'd1000) $display("FAIL busy_latched: got %0d want 1000", bus.alu_rs1); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 32'd999) $display("FAIL busy_late_rsp: got %b/%0d want 1000/999", bus.rsp_valid, bus.rsp_data); else n_pass++;
  endtask

  task automatic test_reset_exec();
    tick();
    set_cmd(2, mk_cmd(32'd0, 32'd40, 32'd2, 12'd0, 5'd0, 7'd0, 3'd0, OP_R));
    tb_valid[2] = 1'b1;
    @(negedge clk);
    n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL rexec_ready: got %b want 0100", bus.req_ready); else n_pass++;
    tick();
    tb_valid[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b1) $display("FAIL rexec_in_exec: got busy %b want 1", bus.busy); else n_pass++;
    tick();
    rst = 1'b0;
    tb_valid = 4'b1111;
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 4'b0) $display("FAIL rexec_no_rsp: got %b want 0000", bus.rsp_valid); else n_pass++;
    n_total++; if (bus.rsp_data !== 32'd0 || bus.rsp_addr !== 32'd0) $display("FAIL rexec_rsp_clr: got %h/%h want 0/0", bus.rsp_data, bus.rsp_addr); else n_pass++;
    n_total++; if (bus.alu_rs1 !== 32'd0 || bus.alu_opcode !== 7'd0 || bus.grant_id !== 2'd0) $display("FAIL rexec_alu_clr: got %h/%h/%0d want 0/0/0", bus.alu_rs1, bus.alu_opcode, bus.grant_id); else n_pass++;
    n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL rexec_ptr: got %b want 0001", bus.req_ready); else n_pass++;
    tick();
    tb_valid = 4'b0;
    tick();
    @(negedge clk);
    n_total++; if (bus.rsp_valid !== 4'b0001) $display("FAIL rexec_next_rsp: got %b want 0001", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_two_req();
    logic [3:0] exp_ready;
    tick();
    tb_valid = 4'b0101;
    for (int k = 0; k < 12; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_ready = (k % 3 == 0) ? 4'b0001 : 4'b0000;
`else
      // Last grant before this test was requester 0, so 2 goes first.
      exp_ready = (k % 3 != 0) ? 4'b0000 : (((k / 3) % 2 == 0) ? 4'b0100 : 4'b0001);
`endif
      @(negedge clk);
      n_total++; if (bus.req_ready !== exp_ready) $display("FAIL two_req c%0d: got %b want %b", k, bus.req_ready, exp_ready); else n_pass++;
      tick();
    end
    tb_valid = 4'b0;
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    tb_valid   = '0;
    tb_cmd_bus = '0;
    rst        = 1'b1;
    test_reset();
    test_single_add();
    test_sub_load();
    test_round_robin();
    test_busy_block();
    test_reset_exec();
    test_two_req();
    @(negedge clk);
    n_total++; if (sb.size() != 0) $display("FAIL sb_leftover: got %0d want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu_top` instance between NUM_REQ requesters (e.g. fetch-side PC adder, branch unit, LSU address generator, debug port).
- Round-robin arbitration, valid/ready command acceptance, registered operand drive into the ALU, captured result returned as a one-cycle response pulse tagged to the winner.
- Sits between the requesting pipeline units and the ALU. It is the ALU's only driver.

Parameters:
- WIDTH, 32, datapath width; matches the ALU WIDTH.
- NUM_REQ, 4, number of requesters, 2..8.
- ID_W, 2, grant id width, equal to clog2(NUM_REQ).
- CMD_W (localparam), 3*WIDTH+34, per-requester command width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_cmd  in  NUM_REQ*CMD_W  requester i at [i*CMD_W +: CMD_W]; fields MSB to LSB are {pc, rs1, rs2, imm[11:0], shamt[4:0], funct7[6:0], funct3[2:0], opcode[6:0]}.
- alu_pc, alu_rs1, alu_rs2  out  WIDTH  registered ALU operands.
- alu_imm  out  12  registered ALU immediate.
- alu_shamt  out  5  registered ALU shift amount.
- alu_funct7  out  7  registered ALU funct7.
- alu_funct3  out  3  registered ALU funct3.
- alu_opcode  out  7  registered ALU opcode.
- alu_rd, alu_mem_addr  in  WIDTH  ALU results.
- rsp_valid  out  NUM_REQ  one-cycle one-hot response pulse.
- rsp_data  out  WIDTH  captured alu_rd.
- rsp_addr  out  WIDTH  captured alu_mem_addr.
- grant_id  out  ID_W  id of the in-flight requester.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset values (applied on rst at a clock edge):
  - all outputs 0; alu_opcode 0, so the ALU yields RD=0;
  - state IDLE;
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. Fixed 3-cycle occupancy per operation, no pipelining.
- IDLE:
  - Winner = first i with req_valid[i], searching (rr_ptr+1) mod NUM_REQ upward with wrap-around.
  - req_ready[winner]=1 combinationally in the same cycle. Handshake occurs at that edge (cycle T).
  - At edge T: latch the winner's command into the alu_* registers, grant_id=winner, rr_ptr=winner, state -> EXEC.
  - No valid request: remain in IDLE, req_ready=0.
- EXEC (cycle T+1):
  - alu_* stable; the ALU evaluates combinationally.
  - At the end of this cycle: rsp_data<=alu_rd, rsp_addr<=alu_mem_addr, state -> RESP.
- RESP (cycle T+2):
  - rsp_valid[grant_id]=1 for exactly one cycle; rsp_data and rsp_addr valid.
  - alu_opcode returns to 0. Other alu_* hold.
  - Next state IDLE, which can accept a new request in the same cycle as the following edge (T+3).
- Requester rules:
  - Must hold req_valid and req_cmd stable until req_ready.
  - req_cmd is sampled only at the handshake edge; changes afterwards do not affect the in-flight operation.
- req_ready is 0 in EXEC and RESP regardless of req_valid.
- rsp_data and rsp_addr hold their last values outside RESP. Only rsp_valid qualifies them.
- A single requester valid continuously is granted every 3 cycles.
- Simultaneous requests: exactly one grant per arbitration, order strictly round-robin from rr_ptr+1.
- Reset mid-operation (EXEC or RESP): operation aborted, no rsp_valid pulse, rr_ptr reinitialised.
- Response has no backpressure: requesters must accept rsp_valid unconditionally.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. rr_ptr is not updated (logic may be removed).
- Undefined (default): round-robin as above.
- FSM, latency and handshake are identical in both builds.

Test Plan:
- Single ADD: req 1 valid with opcode 0110011, funct3 0, funct7 0, rs1 5, rs2 7 -> req_ready[1] at T; rsp_valid = 0010 at T+2; rsp_data 12.
- SUB with load: req 2 sends opcode 0110011, funct7 0x20, rs1 20, rs2 7, and is accepted at T; at edge T+3 req 0 sends load opcode 0000011, rs1 0x100, imm 8 and is accepted -> rsp_data 13 at T+2; rsp_addr 0x108 with rsp_valid[0] at T+5.
- Round-robin: all four valid continuously from reset -> grants 0,1,2,3,0 at cycles 0,3,6,9,12; each rsp_valid exactly 2 cycles after its grant.
- Busy blocking: req 3 raises valid during EXEC of req 0 -> req_ready[3]=0 until IDLE; then granted; response carries req 3's command as held.
- Reset in EXEC: assert rst for one cycle at T+1 -> no rsp_valid; all outputs 0; next grant goes to requester 0 (round-robin) even if rr_ptr was 2.
- ALU_ARB_FIXED_PRIO_EN defined: reqs 0 and 2 valid continuously -> requester 0 granted every 3 cycles; requester 2 never granted while req_valid[0] stays high.
